pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_hazard_det.sv | 15 +
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and constants for the pipeline controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MDU_WAIT = 2'd2
    } pipe_ctrl_state_t;

    localparam logic [31:0] INST_NOP = 32'h00000013;

endpackage

// File: rtl/pipe_hazard_det.sv
// rtl/pipe_hazard_det.sv - combinational load-use hazard compare between execute rd and decode rs1/rs2
module pipe_hazard_det (
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] rd_addr,
    input  logic       reg_wen,
    input  logic       is_load,
    output logic       hazard
);

    // x0 is never a real dependency, so an unused rs field of 0 cannot match
    assign hazard = is_load & reg_wen & (rd_addr != 5'd0) &
                    ((rd_addr == rs1_addr) | (rd_addr == rs2_addr));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/redirect sequencer; PIPE_CTRL_PERF_EN adds stall and flush counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MDU_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_wen,
    input  logic        ex_is_load,
    input  logic        ex_jump_en,
    input  logic [63:0] ex_jump_addr,
    input  logic        ex_mdu_start,
    input  logic        mdu_done,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_hold,
    output logic        redirect_en,
    output logic [63:0] redirect_addr,
    output logic        mdu_timeout_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [63:0] perf_stall_cnt,
    output logic [63:0] perf_flush_cnt
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(MDU_TIMEOUT - 1);

    pipe_ctrl_state_t state, state_next;
    logic [2:0]       flush_cnt, flush_cnt_next;
    logic [7:0]       tmo_cnt, tmo_cnt_next;
    logic             load_use;

    pipe_hazard_det u_hazard (
        .rs1_addr (id_rs1_addr),
        .rs2_addr (id_rs2_addr),
        .rd_addr  (ex_rd_addr),
        .reg_wen  (ex_reg_wen),
        .is_load  (ex_is_load),
        .hazard   (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
            tmo_cnt   <= 8'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            tmo_cnt   <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        flush_cnt_next  = flush_cnt;
        tmo_cnt_next    = tmo_cnt;
        pc_hold         = 1'b0;
        if_id_hold      = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_hold         = 1'b0;
        redirect_en     = 1'b0;
        mdu_timeout_err = 1'b0;
        // reset dominates every event, including the combinational hazard path
        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_jump_en) begin
                        redirect_en    = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        flush_cnt_next = FLUSH_INIT;
                        if (FLUSH_INIT != 3'd0)
                            state_next = FLUSH;
                    end else if (ex_mdu_start) begin
                        state_next   = MDU_WAIT;
                        tmo_cnt_next = 8'd0;
                    end else if (load_use) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    flush_cnt_next = flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1)
                        state_next = RUN;
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state_next = RUN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mdu_timeout_err = 1'b1;
                        state_next      = RUN;
                    end else begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        ex_hold      = 1'b1;
                        tmo_cnt_next = (tmo_cnt == 8'hff) ? tmo_cnt : tmo_cnt + 8'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign redirect_addr = redirect_en ? ex_jump_addr : 64'd0;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= 64'd0;
            perf_flush_cnt <= 64'd0;
        end else begin
            if (pc_hold)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            if (redirect_en)
                perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl (default and minimum flush length)
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        ex_reg_wen, ex_is_load, ex_jump_en, ex_mdu_start, mdu_done;
    logic [63:0] ex_jump_addr;

    logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_hold, redirect_en, mdu_timeout_err;
    logic [63:0] redirect_addr;
    logic        pc_hold_1, if_id_hold_1, if_id_flush_1, id_ex_flush_1, ex_hold_1, redirect_en_1, mdu_timeout_err_1;
    logic [63:0] redirect_addr_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg_wen(ex_reg_wen), .ex_is_load(ex_is_load), .ex_jump_en(ex_jump_en),
        .ex_jump_addr(ex_jump_addr), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_hold(ex_hold), .redirect_en(redirect_en),
        .redirect_addr(redirect_addr), .mdu_timeout_err(mdu_timeout_err)
    );

    pipe_ctrl #(.FLUSH_CYCLES(1), .MDU_TIMEOUT(64)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg_wen(ex_reg_wen), .ex_is_load(ex_is_load), .ex_jump_en(ex_jump_en),
        .ex_jump_addr(ex_jump_addr), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .pc_hold(pc_hold_1), .if_id_hold(if_id_hold_1), .if_id_flush(if_id_flush_1),
        .id_ex_flush(id_ex_flush_1), .ex_hold(ex_hold_1), .redirect_en(redirect_en_1),
        .redirect_addr(redirect_addr_1), .mdu_timeout_err(mdu_timeout_err_1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        ex_reg_wen = 1'b0; ex_is_load = 1'b0; ex_jump_en = 1'b0;
        ex_jump_addr = 64'd0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk); #1;
        check("reset_pc_hold", pc_hold, 0);
        check("reset_if_id_flush", if_id_flush, 0);
        check("reset_redirect_en", redirect_en, 0);
        check("reset_redirect_addr", redirect_addr, 0);
        check("reset_ex_hold", ex_hold, 0);
        check("reset_err", mdu_timeout_err, 0);
        rst = 1'b0;

        // load-use on rs2
        @(negedge clk);
        ex_is_load = 1'b1; ex_reg_wen = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5;
        #1;
        check("lu_pc_hold", pc_hold, 1);
        check("lu_if_id_hold", if_id_hold, 1);
        check("lu_id_ex_flush", id_ex_flush, 1);
        check("lu_ex_hold", ex_hold, 0);
        @(negedge clk); idle(); id_rs2_addr = 5'd5; #1;
        check("lu_after_pc_hold", pc_hold, 0);
        check("lu_after_id_ex_flush", id_ex_flush, 0);
        @(negedge clk);
        ex_is_load = 1'b1; ex_reg_wen = 1'b1; ex_rd_addr = 5'd0; id_rs2_addr = 5'd0; #1;
        check("lu_x0_pc_hold", pc_hold, 0);
        @(negedge clk); ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_rs2_addr = 5'd3; #1;
        check("lu_rs1_pc_hold", pc_hold, 1);
        @(negedge clk); ex_reg_wen = 1'b0; #1;
        check("lu_nowen_pc_hold", pc_hold, 0);

        // jump: default flush length 2 vs minimum 1
        @(negedge clk); idle();
        ex_jump_en = 1'b1; ex_jump_addr = 64'h8000_0040; #1;
        check("jmp_redirect_en", redirect_en, 1);
        check("jmp_redirect_addr", redirect_addr, 64'h8000_0040);
        check("jmp_if_id_flush", if_id_flush, 1);
        check("jmp_id_ex_flush", id_ex_flush, 1);
        check("jmp1_if_id_flush", if_id_flush_1, 1);
        @(negedge clk); idle(); #1;
        check("jmp_c1_redirect_en", redirect_en, 0);
        check("jmp_c1_redirect_addr", redirect_addr, 0);
        check("jmp_c1_if_id_flush", if_id_flush, 1);
        check("jmp_c1_id_ex_flush", id_ex_flush, 1);
        check("jmp1_c1_if_id_flush", if_id_flush_1, 0);
        @(negedge clk); #1;
        check("jmp_c2_if_id_flush", if_id_flush, 0);
        ex_is_load = 1'b1; ex_reg_wen = 1'b1; ex_rd_addr = 5'd9; id_rs1_addr = 5'd9; #1;
        check("jmp_c2_back_in_run", pc_hold, 1);

        // MDU completion after 10 cycles
        @(negedge clk); idle(); ex_mdu_start = 1'b1; #1;
        check("mdu_start_ex_hold", ex_hold, 0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk); ex_mdu_start = 1'b0; #1;
            check("mdu_wait_pc_hold", pc_hold, 1);
            check("mdu_wait_ex_hold", ex_hold, 1);
        end
        @(negedge clk); mdu_done = 1'b1; #1;
        check("mdu_done_pc_hold", pc_hold, 0);
        check("mdu_done_if_id_hold", if_id_hold, 0);
        check("mdu_done_ex_hold", ex_hold, 0);
        check("mdu_done_err", mdu_timeout_err, 0);
        @(negedge clk); #1;
        check("mdu_done_in_run_ignored", ex_hold, 0);
        @(negedge clk); mdu_done = 1'b0; #1;
        check("mdu_after_pc_hold", pc_hold, 0);

        // MDU timeout at cycle 64
        @(negedge clk); ex_mdu_start = 1'b1; #1;
        for (int i = 1; i <= 63; i++) begin
            @(negedge clk); ex_mdu_start = 1'b0; #1;
            check("tmo_wait_ex_hold", ex_hold, 1);
            check("tmo_wait_err", mdu_timeout_err, 0);
        end
        @(negedge clk); #1;
        check("tmo_err_pulse", mdu_timeout_err, 1);
        check("tmo_release_ex_hold", ex_hold, 0);
        check("tmo_release_pc_hold", pc_hold, 0);
        @(negedge clk); #1;
        check("tmo_err_single", mdu_timeout_err, 0);
        check("tmo_after_ex_hold", ex_hold, 0);

        // jump + MDU start + load-use together
        @(negedge clk);
        ex_jump_en = 1'b1; ex_jump_addr = 64'h0000_1234_5678_9abc; ex_mdu_start = 1'b1;
        ex_is_load = 1'b1; ex_reg_wen = 1'b1; ex_rd_addr = 5'd4; id_rs1_addr = 5'd4; #1;
        check("sim_redirect_en", redirect_en, 1);
        check("sim_redirect_addr", redirect_addr, 64'h0000_1234_5678_9abc);
        check("sim_pc_hold", pc_hold, 0);
        check("sim_if_id_flush", if_id_flush, 1);
        @(negedge clk); idle(); #1;
        check("sim_c1_ex_hold", ex_hold, 0);
        check("sim_c1_if_id_flush", if_id_flush, 1);
        @(negedge clk); #1;
        check("sim_c2_if_id_flush", if_id_flush, 0);
        check("sim_c2_pc_hold", pc_hold, 0);

        // reset in the middle of an MDU wait
        @(negedge clk); ex_mdu_start = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ex_mdu_start = 1'b0; #1;
        end
        check("rstmid_ex_hold_before", ex_hold, 1);
        rst = 1'b1; #1;
        check("rstmid_pc_hold", pc_hold, 0);
        check("rstmid_ex_hold", ex_hold, 0);
        check("rstmid_if_id_hold", if_id_hold, 0);
        check("rstmid_err", mdu_timeout_err, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("rstmid_after_ex_hold", ex_hold, 0);
        check("rstmid_after_err", mdu_timeout_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
